// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Pops ASCII bytes from the UART RX FIFO and parses single-letter commands
//   (D/H/S/N, either case) terminated by CR or LF. A parsed command is offered
//   to the game controller on a valid/ready handshake. The letter can optionally
//   be echoed (upper-case) into the UART TX FIFO.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_empty   RX FIFO empty flag
//   r_data     RX FIFO head byte, valid while rx_empty=0
//   rd_uart    RX FIFO pop strobe (combinational)
//   tx_full    TX FIFO full flag
//   wr_uart    TX FIFO push strobe (combinational)
//   w_data     echo byte (registered)
//   cmd_valid  command available (registered)
//   cmd_code   1=deal 2=hit 3=stand 4=new game, 0 when idle (registered)
//   cmd_ready  consumer accepts the command
//   err_pulse  one-cycle protocol error pulse (registered)
//
// States
//   S_IDLE  | waiting for a command letter; stray terminators are dropped
//   S_ECHO  | writing the upper-case letter to the TX FIFO
//   S_ARMED | letter latched, waiting for CR/LF with an idle timeout
//   S_ISSUE | presenting cmd_valid/cmd_code until cmd_ready
//   S_FLUSH | discarding bytes up to and including the next terminator

module uart_cmd_decoder #(
  parameter bit ECHO    = 1'b1,
  parameter int TIMEOUT = 50_000_000,
  parameter int TO_BIT  = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready,
  output logic       err_pulse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ECHO,
    S_ARMED,
    S_ISSUE,
    S_FLUSH
  } state_t;

  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

  state_t            state;
  logic [2:0]        code_q;
  logic [TO_BIT-1:0] to_cnt;
  logic              is_term;
  logic [2:0]        letter;

  always_comb begin
    is_term = (r_data == 8'h0D) || (r_data == 8'h0A);
    case (r_data)
      8'h44, 8'h64: letter = 3'd1;
      8'h48, 8'h68: letter = 3'd2;
      8'h53, 8'h73: letter = 3'd3;
      8'h4E, 8'h6E: letter = 3'd4;
      default:      letter = 3'd0;
    endcase
  end

  // Strobes are gated by rst so the FIFOs never see a pop/push during reset.
  always_comb begin
    rd_uart = !rst && !rx_empty &&
              ((state == S_IDLE) || (state == S_ARMED) || (state == S_FLUSH));
    wr_uart = !rst && (state == S_ECHO) && !tx_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      code_q    <= 3'd0;
      to_cnt    <= '0;
      w_data    <= 8'h00;
      cmd_valid <= 1'b0;
      cmd_code  <= 3'd0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_uart && !is_term) begin
            if (letter != 3'd0) begin
              code_q <= letter;
              w_data <= r_data & 8'hDF;  // clear bit 5: upper-case
              to_cnt <= '0;
              state  <= ECHO ? S_ECHO : S_ARMED;
            end else begin
              err_pulse <= 1'b1;
              state     <= S_FLUSH;
            end
          end
        end
        S_ECHO: begin
          if (wr_uart) begin
            to_cnt <= '0;
            state  <= S_ARMED;
          end
        end
        S_ARMED: begin
          // A byte arriving on the final timeout cycle takes priority.
          if (rd_uart) begin
            if (is_term) begin
              cmd_valid <= 1'b1;
              cmd_code  <= code_q;
              state     <= S_ISSUE;
            end else begin
              err_pulse <= 1'b1;
              code_q    <= 3'd0;
              state     <= S_FLUSH;
            end
          end else if (to_cnt == TO_LAST) begin
            err_pulse <= 1'b1;
            code_q    <= 3'd0;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 3'd0;
            code_q    <= 3'd0;
            state     <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (rd_uart && is_term) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder
//   Self-checking bench for uart_cmd_decoder (ECHO=1, TIMEOUT=16). An RX FIFO
//   model feeds bytes; expected echo bytes and command codes are queued when
//   stimulus is applied and compared as the DUT produces them.

module tb_uart_cmd_decoder;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready = 1'b1;
  logic       err_pulse;

  uart_cmd_decoder #(.ECHO(1'b1), .TIMEOUT(TIMEOUT), .TO_BIT(5)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .cmd_ready(cmd_ready), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  logic [7:0] exp_echo[$];
  logic [2:0] exp_cmd[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int cnt_rd = 0, cnt_wr = 0, cnt_err = 0, cnt_hs = 0, cnt_valid = 0;
  int term_cyc = -10, let_cyc = -10, wr_cyc = -10, err_cyc = -10;
  int b_rd, b_wr, b_err, b_hs, b_valid;
  logic pop_pend = 1'b0;
  logic prev_valid = 1'b0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic snap();
    b_rd = cnt_rd; b_wr = cnt_wr; b_err = cnt_err; b_hs = cnt_hs; b_valid = cnt_valid;
  endtask

  // RX FIFO: pops at the edge where rd_uart was high, then presents the new head.
  task automatic fifo_model();
    forever begin
      @(posedge clk); #2;
      if (pop_pend && rx_q.size() > 0) void'(rx_q.pop_front());
      rx_empty = (rx_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : rx_q[0];
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    logic [2:0] c;
    forever begin
      @(negedge clk);
      cyc++;
      pop_pend = rd_uart;
      if (!rst) begin
        if (rd_uart) begin
          cnt_rd++;
          if (r_data == 8'h0D || r_data == 8'h0A) term_cyc = cyc;
          else let_cyc = cyc;
        end
        if (wr_uart) begin
          cnt_wr++;
          wr_cyc = cyc;
          n_cmp++;
          if (exp_echo.size() == 0) begin
            n_bad++; $display("FAIL echo_unexpected w_data=%h", w_data);
          end else begin
            e = exp_echo.pop_front();
            if (w_data !== e) begin n_bad++; $display("FAIL echo_data got %h want %h", w_data, e); end
          end
        end
        if (err_pulse) begin cnt_err++; err_cyc = cyc; end
        if (cmd_valid) cnt_valid++;
        if (cmd_valid && !prev_valid) begin
          n_cmp++;
          if (cyc != term_cyc + 1) begin
            n_bad++; $display("FAIL cmd_latency got %0d want 1", cyc - term_cyc);
          end
        end
        if (cmd_valid && cmd_ready) begin
          cnt_hs++;
          n_cmp++;
          if (exp_cmd.size() == 0) begin
            n_bad++; $display("FAIL cmd_unexpected code=%0d", cmd_code);
          end else begin
            c = exp_cmd.pop_front();
            if (cmd_code !== c) begin n_bad++; $display("FAIL cmd_code got %0d want %0d", cmd_code, c); end
          end
        end
      end
      prev_valid = cmd_valid;
    end
  endtask

  task automatic watchdog();
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && exp_echo.size() == 0 && exp_cmd.size() == 0 && !cmd_valid) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_wr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wr_uart) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    push(8'h0A);
    repeat (3) @(negedge clk);
    n_cmp++; if (rd_uart !== 1'b0)   begin n_bad++; $display("FAIL reset_rd_uart got %b want 0", rd_uart); end
    n_cmp++; if (wr_uart !== 1'b0)   begin n_bad++; $display("FAIL reset_wr_uart got %b want 0", wr_uart); end
    n_cmp++; if (w_data !== 8'h00)   begin n_bad++; $display("FAIL reset_w_data got %h want 00", w_data); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_valid got %b want 0", cmd_valid); end
    n_cmp++; if (cmd_code !== 3'd0)  begin n_bad++; $display("FAIL reset_cmd_code got %0d want 0", cmd_code); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_err_pulse got %b want 0", err_pulse); end
    snap();
    step(); rst = 1'b0;
    wait_quiet(50, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reset_lf_drain timeout"); end
    n_cmp++; if (cnt_rd - b_rd != 1) begin n_bad++; $display("FAIL reset_lf_pops got %0d want 1", cnt_rd - b_rd); end
    n_cmp++; if (cnt_err != b_err) begin n_bad++; $display("FAIL reset_lf_err got %0d want 0", cnt_err - b_err); end
  endtask

  task automatic test_hit_echo();
    bit ok;
    step();
    exp_echo.push_back(8'h48); exp_cmd.push_back(3'd2);
    snap();
    push(8'h48); push(8'h0D);
    wait_quiet(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL hit_drain timeout"); end
    n_cmp++; if (cnt_wr - b_wr != 1) begin n_bad++; $display("FAIL hit_wr got %0d want 1", cnt_wr - b_wr); end
    n_cmp++; if (cnt_hs - b_hs != 1) begin n_bad++; $display("FAIL hit_cmds got %0d want 1", cnt_hs - b_hs); end
    n_cmp++; if (cnt_valid - b_valid != 1) begin n_bad++; $display("FAIL hit_valid_cycles got %0d want 1", cnt_valid - b_valid); end
    n_cmp++; if (cnt_rd - b_rd != 2) begin n_bad++; $display("FAIL hit_pops got %0d want 2", cnt_rd - b_rd); end
    n_cmp++; if (cnt_err != b_err) begin n_bad++; $display("FAIL hit_err got %0d want 0", cnt_err - b_err); end
    n_cmp++; if (wr_cyc - let_cyc != 1) begin n_bad++; $display("FAIL hit_echo_latency got %0d want 1", wr_cyc - let_cyc); end
  endtask

  task automatic test_extra_lf();
    bit ok;
    step();
    exp_echo.push_back(8'h53); exp_cmd.push_back(3'd3);
    snap();
    push(8'h73); push(8'h0A); push(8'h0A);
    wait_quiet(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL lf_drain timeout"); end
    n_cmp++; if (cnt_hs - b_hs != 1) begin n_bad++; $display("FAIL lf_cmds got %0d want 1", cnt_hs - b_hs); end
    n_cmp++; if (cnt_err != b_err) begin n_bad++; $display("FAIL lf_err got %0d want 0", cnt_err - b_err); end
    n_cmp++; if (cnt_rd - b_rd != 3) begin n_bad++; $display("FAIL lf_pops got %0d want 3", cnt_rd - b_rd); end
  endtask

  task automatic test_bad_letter();
    bit ok;
    step();
    snap();
    push(8'h58); push(8'h0D);
    wait_quiet(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bad_drain timeout"); end
    n_cmp++; if (cnt_err - b_err != 1) begin n_bad++; $display("FAIL bad_err got %0d want 1", cnt_err - b_err); end
    n_cmp++; if (cnt_hs != b_hs) begin n_bad++; $display("FAIL bad_cmds got %0d want 0", cnt_hs - b_hs); end
    n_cmp++; if (cnt_wr != b_wr) begin n_bad++; $display("FAIL bad_wr got %0d want 0", cnt_wr - b_wr); end
    n_cmp++; if (cnt_rd - b_rd != 2) begin n_bad++; $display("FAIL bad_pops got %0d want 2", cnt_rd - b_rd); end
  endtask

  task automatic test_flush();
    bit ok;
    step();
    exp_echo.push_back(8'h48); exp_echo.push_back(8'h44); exp_cmd.push_back(3'd1);
    snap();
    push(8'h48); push(8'h48); push(8'h0D); push(8'h44); push(8'h0D);
    wait_quiet(80, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL flush_drain timeout"); end
    n_cmp++; if (cnt_err - b_err != 1) begin n_bad++; $display("FAIL flush_err got %0d want 1", cnt_err - b_err); end
    n_cmp++; if (cnt_hs - b_hs != 1) begin n_bad++; $display("FAIL flush_cmds got %0d want 1", cnt_hs - b_hs); end
    n_cmp++; if (cnt_wr - b_wr != 2) begin n_bad++; $display("FAIL flush_wr got %0d want 2", cnt_wr - b_wr); end
    n_cmp++; if (cnt_rd - b_rd != 5) begin n_bad++; $display("FAIL flush_pops got %0d want 5", cnt_rd - b_rd); end
  endtask

  task automatic test_timeout();
    bit ok;
    // No terminator: ARMED spends TIMEOUT idle cycles after the echo cycle,
    // and err_pulse shows in the cycle after the last of them.
    step();
    exp_echo.push_back(8'h4E);
    snap();
    push(8'h4E);
    wait_wr(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_echo timeout"); end
    repeat (30) @(negedge clk);
    n_cmp++; if (cnt_err - b_err != 1) begin n_bad++; $display("FAIL to_err got %0d want 1", cnt_err - b_err); end
    n_cmp++; if (cnt_hs != b_hs) begin n_bad++; $display("FAIL to_cmds got %0d want 0", cnt_hs - b_hs); end
    n_cmp++; if (err_cyc - wr_cyc != TIMEOUT + 1) begin n_bad++; $display("FAIL to_delay got %0d want %0d", err_cyc - wr_cyc, TIMEOUT + 1); end
    // Terminator arriving on the final allowed idle cycle wins over the timeout.
    step();
    exp_echo.push_back(8'h4E); exp_cmd.push_back(3'd4);
    snap();
    push(8'h6E);
    wait_wr(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_win_echo timeout"); end
    repeat (TIMEOUT) @(posedge clk);
    #1 push(8'h0D);
    wait_quiet(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_win_drain timeout"); end
    n_cmp++; if (cnt_err != b_err) begin n_bad++; $display("FAIL to_win_err got %0d want 0", cnt_err - b_err); end
    n_cmp++; if (cnt_hs - b_hs != 1) begin n_bad++; $display("FAIL to_win_cmds got %0d want 1", cnt_hs - b_hs); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int stall_bad;
    step();
    cmd_ready = 1'b0;
    exp_echo.push_back(8'h44); exp_echo.push_back(8'h48);
    exp_cmd.push_back(3'd1); exp_cmd.push_back(3'd2);
    snap();
    push(8'h44); push(8'h0D); push(8'h48); push(8'h0D);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_valid) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_valid timeout"); end
    stall_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_code !== 3'd1 || rd_uart !== 1'b0) stall_bad++;
    end
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL b2b_stall_unstable got %0d bad cycles want 0", stall_bad); end
    n_cmp++; if (rx_q.size() != 2) begin n_bad++; $display("FAIL b2b_rx_backlog got %0d want 2", rx_q.size()); end
    step();
    cmd_ready = 1'b1;
    wait_quiet(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_drain timeout"); end
    n_cmp++; if (cnt_hs - b_hs != 2) begin n_bad++; $display("FAIL b2b_cmds got %0d want 2", cnt_hs - b_hs); end
  endtask

  task automatic test_tx_full();
    bit ok;
    step();
    tx_full = 1'b1;
    exp_echo.push_back(8'h48); exp_cmd.push_back(3'd2);
    snap();
    push(8'h68); push(8'h0D);
    repeat (10) @(negedge clk);
    n_cmp++; if (cnt_wr != b_wr) begin n_bad++; $display("FAIL txf_wr_while_full got %0d want 0", cnt_wr - b_wr); end
    n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL txf_rx_backlog got %0d want 1", rx_q.size()); end
    step();
    tx_full = 1'b0;
    wait_quiet(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL txf_drain timeout"); end
    n_cmp++; if (cnt_wr - b_wr != 1) begin n_bad++; $display("FAIL txf_wr got %0d want 1", cnt_wr - b_wr); end
    n_cmp++; if (cnt_hs - b_hs != 1) begin n_bad++; $display("FAIL txf_cmds got %0d want 1", cnt_hs - b_hs); end
  endtask

  task automatic test_reset_armed();
    bit ok;
    step();
    exp_echo.push_back(8'h53);
    snap();
    push(8'h53);
    wait_wr(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rsta_echo timeout"); end
    step();
    @(negedge clk);
    n_cmp++; if (w_data !== 8'h53) begin n_bad++; $display("FAIL rsta_w_data_held got %h want 53", w_data); end
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    n_cmp++; if (rd_uart !== 1'b0)   begin n_bad++; $display("FAIL rsta_rd_uart got %b want 0", rd_uart); end
    n_cmp++; if (wr_uart !== 1'b0)   begin n_bad++; $display("FAIL rsta_wr_uart got %b want 0", wr_uart); end
    n_cmp++; if (w_data !== 8'h00)   begin n_bad++; $display("FAIL rsta_w_data got %h want 00", w_data); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rsta_cmd_valid got %b want 0", cmd_valid); end
    n_cmp++; if (cmd_code !== 3'd0)  begin n_bad++; $display("FAIL rsta_cmd_code got %0d want 0", cmd_code); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL rsta_err_pulse got %b want 0", err_pulse); end
    step();
    rst = 1'b0;
    push(8'h0D);
    wait_quiet(60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rsta_drain timeout"); end
    n_cmp++; if (cnt_hs != b_hs) begin n_bad++; $display("FAIL rsta_cmds got %0d want 0", cnt_hs - b_hs); end
    n_cmp++; if (cnt_err != b_err) begin n_bad++; $display("FAIL rsta_err got %0d want 0", cnt_err - b_err); end
  endtask

  initial begin
    fork
      fifo_model();
      monitor();
      watchdog();
    join_none
    test_reset();
    test_hit_echo();
    test_extra_lf();
    test_bad_letter();
    test_flush();
    test_timeout();
    test_back_to_back();
    test_tx_full();
    test_reset_armed();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
